// File: rtl/commit_fifo.sv
// Commit-record FIFO: accepts up to NRET in-order retire records per cycle and
// presents one record per cycle to the iaddr/iretire/ilastsize stage.
package mure_pkg;
  typedef struct packed {
    logic        valid;
    logic [2:0]  itype;
    logic        compressed;
    logic [63:0] pc;
    logic [63:0] cause;
    logic [63:0] tval;
    logic [1:0]  priv;
  } fifo_entry_s;
endpackage

// Handshake: valid_i[k] offers entry_i[k] for exactly the current cycle. There is
// no ready in either direction. Records that do not fit are dropped, and
// overflow_o records the loss. The head is consumed at every edge while non-empty.
module commit_fifo #(
  parameter int DEPTH = 16,
  parameter int NRET  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NRET-1:0]                   valid_i,
  input  mure_pkg::fifo_entry_s [NRET-1:0]  entry_i,
  output mure_pkg::fifo_entry_s             fifo_entry_o,
  output logic                              empty_o,
  output logic                              full_o,
  output logic [$clog2(DEPTH+1)-1:0]        count_o,
  output logic                              overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  mure_pkg::fifo_entry_s mem_q [DEPTH];

  logic                  empty, pop, drop;
  logic [CW-1:0]         free_slots, n_acc;
  logic [NRET-1:0]       accept;
  logic [PW-1:0]         slot [NRET];

  assign empty      = (count_q == '0);
  assign pop        = !empty;
  // The same-edge pop frees a slot that the push may reuse.
  assign free_slots = CW'(DEPTH) - count_q + CW'(pop);

  // Compact active ports in ascending order; the oldest pushes win when space runs out.
  always_comb begin
    n_acc  = '0;
    accept = '0;
    drop   = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      slot[k] = wr_ptr_q + PW'(n_acc);
      if (valid_i[k]) begin
        if (n_acc < free_slots) begin
          accept[k] = 1'b1;
          n_acc     = n_acc + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      wr_ptr_q <= wr_ptr_q + PW'(n_acc);
      count_q  <= count_q - CW'(pop) + n_acc;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int k = 0; k < NRET; k++) begin
        if (accept[k]) mem_q[slot[k]] <= entry_i[k];
      end
    end
  end

  // Empty must present all zeros: downstream decodes itype without looking at valid.
  always_comb begin
    fifo_entry_o = '0;
    if (!empty) begin
      fifo_entry_o       = mem_q[rd_ptr_q];
      fifo_entry_o.valid = 1'b1;
    end
  end

  assign empty_o    = empty;
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_commit_fifo.sv
// Directed bench for commit_fifo: push/pop ordering, gaps, overflow, exception records, flush, reset.
module tb_commit_fifo;
  localparam int DEPTH = 16;
  localparam int NRET  = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic                             clk_i = 1'b0;
  logic                             rst_ni;
  logic                             flush_i;
  logic [NRET-1:0]                  valid_i;
  mure_pkg::fifo_entry_s [NRET-1:0] entry_i;
  mure_pkg::fifo_entry_s            fifo_entry_o;
  logic                             empty_o, full_o, overflow_o;
  logic [CW-1:0]                    count_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  commit_fifo #(.DEPTH(DEPTH), .NRET(NRET)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .entry_i(entry_i), .fifo_entry_o(fifo_entry_o), .empty_o(empty_o),
    .full_o(full_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Incoming valid is left 0 to show the stored valid comes from occupancy.
  function automatic mure_pkg::fifo_entry_s mk(input logic [63:0] pc, input logic [2:0] itype,
                                               input logic comp, input logic [63:0] cause,
                                               input logic [63:0] tval);
    mure_pkg::fifo_entry_s e;
    e            = '0;
    e.itype      = itype;
    e.compressed = comp;
    e.pc         = pc;
    e.cause      = cause;
    e.tval       = tval;
    e.priv       = 2'b11;
    return e;
  endfunction

  function automatic mure_pkg::fifo_entry_s head(input mure_pkg::fifo_entry_s e);
    mure_pkg::fifo_entry_s h;
    h       = e;
    h.valid = 1'b1;
    return h;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input mure_pkg::fifo_entry_s e0,
                       input mure_pkg::fifo_entry_s e1);
    valid_i    = v;
    entry_i[0] = e0;
    entry_i[1] = e1;
  endtask

  task automatic idle();
    valid_i = '0;
    entry_i = '0;
    flush_i = 1'b0;
  endtask

  mure_pkg::fifo_entry_s exc;

  initial begin
    rst_ni = 1'b0;
    idle();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    check("rst_empty", 256'(empty_o), 256'(1));
    check("rst_full", 256'(full_o), 256'(0));
    check("rst_count", 256'(count_o), 256'(0));
    check("rst_ovf", 256'(overflow_o), 256'(0));
    check("rst_entry", 256'(fifo_entry_o), 256'(0));

    // single push, visible one cycle, consumed at the next edge
    drive(2'b01, mk(64'h8000_0000, 3'd0, 1'b1, 64'd0, 64'd0), '0);
    tick(); idle();
    check("single_head", 256'(fifo_entry_o), 256'(head(mk(64'h8000_0000, 3'd0, 1'b1, 64'd0, 64'd0))));
    check("single_count", 256'(count_o), 256'(1));
    tick();
    check("single_drained", 256'(empty_o), 256'(1));
    check("single_zero", 256'(fifo_entry_o), 256'(0));

    // dual push every cycle until full, then two overflowing cycles
    for (int k = 1; k <= 17; k++) begin
      drive(2'b11, mk(64'h100 + 64'(8*(k-1)), 3'd0, 1'b0, 64'd0, 64'd0),
                   mk(64'h104 + 64'(8*(k-1)), 3'd0, 1'b0, 64'd0, 64'd0));
      tick();
      check("stream_head", 256'(fifo_entry_o),
            256'(head(mk(64'h100 + 64'(4*(k-1)), 3'd0, 1'b0, 64'd0, 64'd0))));
      check("stream_count", 256'(count_o), 256'((k + 1 < 16) ? k + 1 : 16));
      check("stream_full", 256'(full_o), 256'(k >= 15));
      check("stream_ovf", 256'(overflow_o), 256'(k >= 16));
    end
    idle();

    // scoreboard: records r16..r29, then r30 and r32 (r31, r33 dropped)
    for (int j = 16; j <= 29; j++) exp_q.push_back(64'h100 + 64'(4*j));
    exp_q.push_back(64'h100 + 64'(4*30));
    exp_q.push_back(64'h100 + 64'(4*32));
    for (int i = 0; i < 16; i++) begin
      check("drain_pc", 256'(fifo_entry_o.pc), 256'(exp_q.pop_front()));
      check("drain_count", 256'(count_o), 256'(16 - i));
      tick();
    end
    check("drain_empty", 256'(empty_o), 256'(1));
    check("drain_ovf_sticky", 256'(overflow_o), 256'(1));

    // gap push: only port 1 active
    drive(2'b10, mk(64'hBAD, 3'd0, 1'b0, 64'd0, 64'd0), mk(64'h200, 3'd0, 1'b0, 64'd0, 64'd0));
    tick(); idle();
    check("gap_head", 256'(fifo_entry_o), 256'(head(mk(64'h200, 3'd0, 1'b0, 64'd0, 64'd0))));
    check("gap_count", 256'(count_o), 256'(1));
    tick();
    check("gap_empty", 256'(empty_o), 256'(1));
    check("empty_itype", 256'(fifo_entry_o.itype), 256'(0));

    // exception record queued behind three ordinary records
    exc = mk(64'h30C, 3'd1, 1'b0, 64'd2, 64'hDEAD);
    drive(2'b11, mk(64'h300, 3'd0, 1'b0, 64'd0, 64'd0), mk(64'h304, 3'd0, 1'b0, 64'd0, 64'd0));
    tick();
    check("exc_out1", 256'(fifo_entry_o.pc), 256'(64'h300));
    drive(2'b11, mk(64'h308, 3'd0, 1'b0, 64'd0, 64'd0), exc);
    tick(); idle();
    check("exc_count", 256'(count_o), 256'(3));
    check("exc_out2", 256'(fifo_entry_o.pc), 256'(64'h304));
    tick();
    check("exc_out3", 256'(fifo_entry_o.pc), 256'(64'h308));
    tick();
    check("exc_out4", 256'(fifo_entry_o), 256'(head(exc)));
    tick();
    check("exc_empty_itype", 256'(fifo_entry_o.itype), 256'(0));
    check("exc_empty_entry", 256'(fifo_entry_o), 256'(0));

    // build count 5, then flush with a same-cycle dual push
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, mk(64'h400 + 64'(8*k), 3'd0, 1'b0, 64'd0, 64'd0),
                   mk(64'h404 + 64'(8*k), 3'd0, 1'b0, 64'd0, 64'd0));
      tick();
    end
    check("preflush_count", 256'(count_o), 256'(5));
    drive(2'b11, mk(64'h500, 3'd0, 1'b0, 64'd0, 64'd0), mk(64'h504, 3'd0, 1'b0, 64'd0, 64'd0));
    flush_i = 1'b1;
    tick(); idle();
    check("flush_count", 256'(count_o), 256'(0));
    check("flush_empty", 256'(empty_o), 256'(1));
    check("flush_entry", 256'(fifo_entry_o), 256'(0));
    check("flush_ovf_kept", 256'(overflow_o), 256'(1));
    tick();
    check("flush_no_ghost", 256'(empty_o), 256'(1));

    // asynchronous reset in the middle of a cycle
    drive(2'b11, mk(64'h600, 3'd0, 1'b0, 64'd0, 64'd0), mk(64'h604, 3'd0, 1'b0, 64'd0, 64'd0));
    tick(); idle();
    check("prereset_count", 256'(count_o), 256'(2));
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_entry", 256'(fifo_entry_o), 256'(0));
    check("async_rst_count", 256'(count_o), 256'(0));
    check("async_rst_ovf", 256'(overflow_o), 256'(0));
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_rst_empty", 256'(empty_o), 256'(1));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
